mc_ctrl_fsm: RTL

//  Main control FSM for the multi-cycle MIPS core; sits directly upstream of the ALU.

---
 rtl/mc_defs_pkg.sv | 65 ++++++
 rtl/mc_alu_dec.sv | 56 +++++
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_defs_pkg.sv
// mc_defs: shared encodings for the multi-cycle MIPS control path.
//   - ALU_*_OP : 4-bit ALU operation codes driven on alu_op
//   - OP_*/FN_*: instruction opcode (IR[31:26]) and funct (IR[5:0]) values
//   - state_t  : control FSM state encodings, also visible on the state port
// Optional feature macro: MC_CTRL_JAL_JR_EN (jal/jr support in the FSM and decoder).
package mc_defs;

  localparam logic [3:0] ALU_ADDU_OP  = 4'd0;
  localparam logic [3:0] ALU_SUBU_OP  = 4'd1;
  localparam logic [3:0] ALU_ADD_OP   = 4'd2;
  localparam logic [3:0] ALU_SUB_OP   = 4'd3;
  localparam logic [3:0] ALU_AND_OP   = 4'd4;
  localparam logic [3:0] ALU_OR_OP    = 4'd5;
  localparam logic [3:0] ALU_XOR_OP   = 4'd6;
  localparam logic [3:0] ALU_NOR_OP   = 4'd7;
  localparam logic [3:0] ALU_SLT_OP   = 4'd8;
  localparam logic [3:0] ALU_SLTU_OP  = 4'd9;
  localparam logic [3:0] ALU_ORI_OP   = 4'd10;
  localparam logic [3:0] ALU_ADDI_OP  = 4'd11;
  localparam logic [3:0] ALU_ADDIU_OP = 4'd12;
  localparam logic [3:0] ALU_ANDI_OP  = 4'd13;
  localparam logic [3:0] ALU_XORI_OP  = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational instruction decoder feeding the control FSM.
// Ports:
//   i_opcode [5:0] : IR[31:26]
//   i_funct  [5:0] : IR[5:0]
//   o_alu_op [3:0] : ALU operation for EXEC (from funct) or IEXEC (from opcode)
//   o_ext_op       : 1 = sign-extend immediate, 0 = zero-extend (logical immediates)
//   o_legal        : instruction is supported by this core
// Macro MC_CTRL_JAL_JR_EN: when defined, jal and jr are accepted as legal.
module mc_alu_dec
  import mc_defs::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_ext_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADDU_OP;
    o_ext_op = 1'b1;
    o_legal  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_legal = 1'b1;
        case (i_funct)
          FN_ADDU: o_alu_op = ALU_ADDU_OP;
          FN_SUBU: o_alu_op = ALU_SUBU_OP;
          FN_ADD:  o_alu_op = ALU_ADD_OP;
          FN_SUB:  o_alu_op = ALU_SUB_OP;
          FN_AND:  o_alu_op = ALU_AND_OP;
          FN_OR:   o_alu_op = ALU_OR_OP;
          FN_XOR:  o_alu_op = ALU_XOR_OP;
          FN_NOR:  o_alu_op = ALU_NOR_OP;
          FN_SLT:  o_alu_op = ALU_SLT_OP;
          FN_SLTU: o_alu_op = ALU_SLTU_OP;
`ifdef MC_CTRL_JAL_JR_EN
          FN_JR:   o_alu_op = ALU_ADDU_OP;
`endif
          default: o_legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_J: o_legal = 1'b1;
`ifdef MC_CTRL_JAL_JR_EN
      OP_JAL: o_legal = 1'b1;
`endif
      OP_ORI:   begin o_alu_op = ALU_ORI_OP;   o_ext_op = 1'b0; o_legal = 1'b1; end
      OP_ANDI:  begin o_alu_op = ALU_ANDI_OP;  o_ext_op = 1'b0; o_legal = 1'b1; end
      OP_XORI:  begin o_alu_op = ALU_XORI_OP;  o_ext_op = 1'b0; o_legal = 1'b1; end
      OP_ADDI:  begin o_alu_op = ALU_ADDI_OP;  o_legal = 1'b1; end
      OP_ADDIU: begin o_alu_op = ALU_ADDIU_OP; o_legal = 1'b1; end
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM of the multi-cycle MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and the ALU
// operation, resolves beq from the ALU zero flag and counts retired instructions.
// Ports:
//   clk, rst (sync, active-high)      opcode/funct : IR fields   zf : ALU zero flag
//   pc_we, ir_we, mem_we, rf_we       : write enables
//   iord, reg_dst, mem_to_reg, alusrc_a, alusrc_b, ext_op, alu_op, pc_src : mux/ALU controls
//   illegal : DECODE-cycle pulse for unsupported instructions
//   state   : current state (trace)   instr_cnt : retired instruction count (wraps)
// Macro MC_CTRL_JAL_JR_EN: when defined, adds the JAL (12) and JR (13) states.
module mc_ctrl_fsm
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zf,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_we,
  output logic             rf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic             ext_op,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_retire;
  logic [3:0]        w_dec_alu_op;
  logic              w_dec_ext_op;
  logic              w_dec_legal;

  mc_alu_dec u_dec (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_alu_op (w_dec_alu_op),
    .o_ext_op (w_dec_ext_op),
    .o_legal  (w_dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign instr_cnt = r_cnt;

  always_comb begin
    w_next     = S_FETCH;
    w_retire   = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alusrc_a   = 1'b0;
    alusrc_b   = 2'd0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADDU_OP;
    pc_src     = 2'd0;
    illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        ir_we    = 1'b1;
        pc_we    = 1'b1;
        alusrc_b = 2'd1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        // ALU speculatively forms the branch target while the opcode is decoded.
        alusrc_b = 2'd3;
        ext_op   = 1'b1;
        if (!w_dec_legal) begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
`ifdef MC_CTRL_JAL_JR_EN
            OP_RTYPE:     w_next = (funct == FN_JR) ? S_JR : S_EXEC;
            OP_JAL:       w_next = S_JAL;
`else
            OP_RTYPE:     w_next = S_EXEC;
`endif
            OP_BEQ:       w_next = S_BRANCH;
            OP_J:         w_next = S_JUMP;
            OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_XORI: w_next = S_IEXEC;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        ext_op   = 1'b1;
        w_next   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        mem_to_reg = 2'd1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_we   = 1'b1;
        w_retire = 1'b1;
      end
      S_EXEC: begin
        alusrc_a = 1'b1;
        alu_op   = w_dec_alu_op;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        reg_dst  = 2'd1;
        w_retire = 1'b1;
      end
      S_IEXEC: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        ext_op   = w_dec_ext_op;
        alu_op   = w_dec_alu_op;
        w_next   = S_IWB;
      end
      S_IWB: begin
        rf_we    = 1'b1;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        // Mealy: take the branch in the same cycle the ALU compares A and B.
        alusrc_a = 1'b1;
        alu_op   = ALU_SUBU_OP;
        pc_src   = 2'd1;
        pc_we    = zf;
        w_retire = 1'b1;
      end
      S_JUMP: begin
        pc_we    = 1'b1;
        pc_src   = 2'd2;
        w_retire = 1'b1;
      end
`ifdef MC_CTRL_JAL_JR_EN
      S_JAL: begin
        rf_we      = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        pc_we      = 1'b1;
        pc_src     = 2'd2;
        w_retire   = 1'b1;
      end
      S_JR: begin
        pc_we    = 1'b1;
        pc_src   = 2'd3;
        w_retire = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase

    // While in reset, present FETCH mux settings with every enable held low.
    if (rst) begin
      w_next     = S_FETCH;
      w_retire   = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_we     = 1'b0;
      rf_we      = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alusrc_a   = 1'b0;
      alusrc_b   = 2'd1;
      ext_op     = 1'b0;
      alu_op     = ALU_ADDU_OP;
      pc_src     = 2'd0;
      illegal    = 1'b0;
    end
  end

endmodule
